writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus write-back driver for the pipelined MIPS core.
- It is the producer side of the register-file write port: it latches MEM-stage results and selects ALU versus load data.
- It drives write_reg_num, write_data and regWrite into the register file.
- It also exports a forwarding tap for the EX-stage hazard logic and a retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, width of register data.
- REG_ADDR_WIDTH, 5, register number width (32 registers).
- COUNT_WIDTH, 32, retired-instruction counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mem_valid  input  1  MEM stage holds a real instruction (0 = bubble).
- mem_reg_write  input  1  instruction writes a register.
- mem_mem_to_reg  input  1  1 = write load data, 0 = write ALU result.
- mem_write_reg_num  input  REG_ADDR_WIDTH  destination register.
- mem_alu_result  input  DATA_WIDTH  ALU result from MEM stage.
- mem_read_data  input  DATA_WIDTH  data-memory load result.
- stall  input  1  hold WB contents, do not capture.
- flush  input  1  capture a bubble instead of MEM contents.
- write_reg_num  output  REG_ADDR_WIDTH  to register file.
- write_data  output  DATA_WIDTH  to register file.
- regWrite  output  1  register-file write enable.
- wb_valid  output  1  WB stage holds a real instruction.
- fwd_valid  output  1  forwarding tap valid; equals regWrite.
- fwd_reg_num  output  REG_ADDR_WIDTH  equals write_reg_num.
- fwd_data  output  DATA_WIDTH  equals write_data.
- retired_count  output  COUNT_WIDTH  instructions retired since reset.

Behaviour:
- Reset (async, active-high): all pipeline registers cleared.
  - wb_valid=0, regWrite=0, fwd_valid=0.
  - write_reg_num=0, write_data=0, retired_count=0.
  - Outputs go to these values immediately on reset assertion, independent of clk.
- Capture on each rising clk edge with reset low, priority flush > stall > normal:
  - flush=1: load a bubble (valid=0, reg_write=0, reg_num=0, both data=0), regardless of stall.
  - stall=1, flush=0: hold every pipeline register unchanged.
  - otherwise: load all mem_* inputs.
- Latency: exactly one cycle from MEM inputs to the register-file outputs.
- write_data is combinational from registered fields: wb_mem_to_reg ? wb_read_data : wb_alu_result.
- regWrite = wb_valid & wb_reg_write & (write_reg_num != 0).
  - Writes to $0 are suppressed; write_reg_num and write_data still show the latched values.
- During a stall the same write is presented on consecutive cycles. This is idempotent and permitted.
- A bubble (mem_valid=0) with mem_reg_write=1 never produces regWrite=1.
- Forwarding tap is pure wiring: fwd_* mirrors regWrite/write_reg_num/write_data in the same cycle.
- retired_count increments by 1 on an edge where wb_valid=1 and (stall=0 or flush=1), i.e. the resident instruction leaves WB.
  - Wraps from 2^COUNT_WIDTH-1 to 0 with no saturation or flag.
- Reset mid-stall or mid-flush: reset wins; the state after deassertion is the reset state. The first capture happens on the first edge after deassertion.

Decomposition:
- Shared package mips_pkg: DATA_WIDTH, REG_ADDR_WIDTH, REG_ZERO (5'd0), and a wb_ctrl struct/typedef {valid, reg_write, mem_to_reg}, reused by the EX/MEM register.
- One sub-module, retire_counter: COUNT_WIDTH-wide counter with async active-high reset and an inc input. The top level computes inc.

Test Plan:
- Reset then ALU write: reset=1, release, then mem_valid=1, reg_write=1, mem_to_reg=0, reg_num=2, alu_result=32'h0002FA41 → next cycle regWrite=1, write_reg_num=2, write_data=32'h0002FA41; retired_count=1 one edge later.
- Load select: mem_to_reg=1, read_data=32'hDEADBEEF, alu_result=32'h00001000, reg_num=17 → write_data=32'hDEADBEEF, regWrite=1, fwd_reg_num=17.
- $0 suppression: reg_num=0, reg_write=1, alu_result=32'hFFFFFFFF → regWrite=0, fwd_valid=0, wb_valid=1; retired_count still increments.
- Stall/flush priority:
  - With reg 18 resident, stall=1 for 3 cycles while mem inputs change → outputs frozen (reg 18) and retired_count unchanged.
  - Then stall=1 and flush=1 together → next cycle wb_valid=0, regWrite=0, and count +1.
- Async reset mid-operation: assert reset between clk edges while regWrite=1 → regWrite, write_data and retired_count go to 0 before the next edge.
- Counter wrap: COUNT_WIDTH=4, retire 16 instructions back-to-back → retired_count reads 15, then 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and write-back control bundle for the pipelined MIPS core
package mips_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;
endpackage

// File: rtl/writeback_stage_retire_counter.sv
// retire_counter: free-running wrap-around count of instructions leaving WB
module retire_counter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_inc,
  output logic [COUNT_WIDTH-1:0] o_count
);
  // count up on each retire, wrapping silently
  always_ff @(posedge clk or posedge rst)
    if (rst) o_count <= '0;
    else if (i_inc) o_count <= o_count + 1'b1;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, register-file write driver, forwarding tap, retire counter
module writeback_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_valid,
  input  logic                      mem_reg_write,
  input  logic                      mem_mem_to_reg,
  input  logic [REG_ADDR_WIDTH-1:0] mem_write_reg_num,
  input  logic [DATA_WIDTH-1:0]     mem_alu_result,
  input  logic [DATA_WIDTH-1:0]     mem_read_data,
  input  logic                      stall,
  input  logic                      flush,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_num,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic                      regWrite,
  output logic                      wb_valid,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_reg_num,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output logic [COUNT_WIDTH-1:0]    retired_count
);
  import mips_pkg::*;
  wb_ctrl_t                  r_ctrl;
  logic [REG_ADDR_WIDTH-1:0] r_reg_num;
  logic [DATA_WIDTH-1:0]     r_alu_result;
  logic [DATA_WIDTH-1:0]     r_read_data;
  logic                      w_retire;
  // pipeline register: flush beats stall beats normal capture
  always_ff @(posedge clk or posedge reset)
    if (reset || flush) begin
      r_ctrl       <= '0;
      r_reg_num    <= '0;
      r_alu_result <= '0;
      r_read_data  <= '0;
    end else if (!stall) begin
      r_ctrl       <= '{valid: mem_valid, reg_write: mem_reg_write, mem_to_reg: mem_mem_to_reg};
      r_reg_num    <= mem_write_reg_num;
      r_alu_result <= mem_alu_result;
      r_read_data  <= mem_read_data;
    end
  // the resident instruction leaves WB unless it is held by a stall
  assign w_retire = r_ctrl.valid & (~stall | flush);
  assign write_reg_num = r_reg_num;
  assign write_data = r_ctrl.mem_to_reg ? r_read_data : r_alu_result;
  assign wb_valid = r_ctrl.valid;
  assign regWrite = r_ctrl.valid & r_ctrl.reg_write & (r_reg_num != REG_ADDR_WIDTH'(REG_ZERO));
  assign fwd_valid = regWrite;
  assign fwd_reg_num = write_reg_num;
  assign fwd_data = write_data;
  retire_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_retire (
    .clk(clk),
    .rst(reset),
    .i_inc(w_retire),
    .o_count(retired_count)
  );
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: table vectors, hand sequences and randomized model check of writeback_stage
module tb_writeback_stage;
  logic clk = 1'b0;
  logic reset, mem_valid, mem_reg_write, mem_mem_to_reg, stall, flush;
  logic [4:0] mem_write_reg_num;
  logic [31:0] mem_alu_result, mem_read_data;
  logic [4:0] write_reg_num, fwd_reg_num, write_reg_num4, fwd_reg_num4;
  logic [31:0] write_data, fwd_data, retired_count, write_data4, fwd_data4;
  logic regWrite, wb_valid, fwd_valid, regWrite4, wb_valid4, fwd_valid4;
  logic [3:0] retired_count4;
  int n_vec = 0, n_bad = 0;
  logic m_valid, m_rw;
  logic [4:0] m_num;
  logic [31:0] m_data, m_cnt;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_write_reg_num(mem_write_reg_num),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data), .stall(stall), .flush(flush),
    .write_reg_num(write_reg_num), .write_data(write_data), .regWrite(regWrite), .wb_valid(wb_valid),
    .fwd_valid(fwd_valid), .fwd_reg_num(fwd_reg_num), .fwd_data(fwd_data), .retired_count(retired_count)
  );

  writeback_stage #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_write_reg_num(mem_write_reg_num),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data), .stall(stall), .flush(flush),
    .write_reg_num(write_reg_num4), .write_data(write_data4), .regWrite(regWrite4), .wb_valid(wb_valid4),
    .fwd_valid(fwd_valid4), .fwd_reg_num(fwd_reg_num4), .fwd_data(fwd_data4), .retired_count(retired_count4)
  );

  typedef struct {
    logic v, rw, m2r;
    logic [4:0] n;
    logic [31:0] alu, rd;
    logic st, fl;
    logic ewr;
    logic [4:0] en;
    logic [31:0] ed;
    logic ev;
    logic [31:0] ec;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, rw, m2r, input logic [4:0] n, input logic [31:0] alu, rd, input logic st, fl);
    mem_valid = v; mem_reg_write = rw; mem_mem_to_reg = m2r; mem_write_reg_num = n;
    mem_alu_result = alu; mem_read_data = rd; stall = st; flush = fl;
  endtask

  // what the WB stage holds after an edge, stated as "instruction in flight" rather than raw fields
  task automatic model_edge();
    if (flush) begin
      m_cnt += 32'(m_valid);
      m_valid = 0; m_rw = 0; m_num = 0; m_data = 0;
    end else if (!stall) begin
      m_cnt += 32'(m_valid);
      m_valid = mem_valid; m_rw = mem_reg_write; m_num = mem_write_reg_num;
      m_data = mem_mem_to_reg ? mem_read_data : mem_alu_result;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic exp_wr;
    exp_wr = m_valid && m_rw && m_num != 0;
    check({tag, ".regWrite"}, 32'(regWrite), 32'(exp_wr));
    check({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(exp_wr));
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'(m_valid));
    check({tag, ".num"}, 32'(write_reg_num), 32'(m_num));
    check({tag, ".fwd_num"}, 32'(fwd_reg_num), 32'(m_num));
    check({tag, ".data"}, write_data, m_data);
    check({tag, ".fwd_data"}, fwd_data, m_data);
    check({tag, ".count"}, retired_count, m_cnt);
    check({tag, ".count4"}, 32'(retired_count4), m_cnt % 16);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    m_valid = 0; m_rw = 0; m_num = 0; m_data = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    tbl[0] = '{1, 1, 0, 5'd2,  32'h0002FA41, 32'h0,        0, 0, 1, 5'd2,  32'h0002FA41, 1, 0};
    tbl[1] = '{1, 1, 1, 5'd17, 32'h00001000, 32'hDEADBEEF, 0, 0, 1, 5'd17, 32'hDEADBEEF, 1, 1};
    tbl[2] = '{1, 1, 0, 5'd0,  32'hFFFFFFFF, 32'h0,        0, 0, 0, 5'd0,  32'hFFFFFFFF, 1, 2};
    tbl[3] = '{1, 1, 0, 5'd18, 32'h00000018, 32'h0,        0, 0, 1, 5'd18, 32'h00000018, 1, 3};
    tbl[4] = '{1, 1, 0, 5'd5,  32'h00000055, 32'h0,        1, 0, 1, 5'd18, 32'h00000018, 1, 3};
    tbl[5] = '{1, 0, 1, 5'd6,  32'h00000066, 32'h12345678, 1, 0, 1, 5'd18, 32'h00000018, 1, 3};
    tbl[6] = '{0, 1, 0, 5'd7,  32'h00000077, 32'h0,        1, 0, 1, 5'd18, 32'h00000018, 1, 3};
    tbl[7] = '{1, 1, 0, 5'd8,  32'h00000088, 32'h0,        1, 1, 0, 5'd0,  32'h00000000, 0, 4};
    tbl[8] = '{0, 1, 0, 5'd9,  32'h00000099, 32'h0,        0, 0, 0, 5'd9,  32'h00000099, 0, 4};
    tbl[9] = '{1, 0, 1, 5'd3,  32'h00000033, 32'hCAFEF00D, 0, 0, 0, 5'd3,  32'hCAFEF00D, 1, 4};

    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("reset.regWrite", 32'(regWrite), 0);
    check("reset.wb_valid", 32'(wb_valid), 0);
    check("reset.data", write_data, 0);
    check("reset.count", retired_count, 0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].rw, tbl[i].m2r, tbl[i].n, tbl[i].alu, tbl[i].rd, tbl[i].st, tbl[i].fl);
      tick();
      check($sformatf("tbl%0d.regWrite", i), 32'(regWrite), 32'(tbl[i].ewr));
      check($sformatf("tbl%0d.fwd_valid", i), 32'(fwd_valid), 32'(tbl[i].ewr));
      check($sformatf("tbl%0d.num", i), 32'(write_reg_num), 32'(tbl[i].en));
      check($sformatf("tbl%0d.fwd_num", i), 32'(fwd_reg_num), 32'(tbl[i].en));
      check($sformatf("tbl%0d.data", i), write_data, tbl[i].ed);
      check($sformatf("tbl%0d.wb_valid", i), 32'(wb_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d.count", i), retired_count, tbl[i].ec);
    end
    check_model("tbl_end");

    drive(1, 1, 0, 5'd12, 32'hA5A5A5A5, 0, 0, 0);
    tick();
    check_model("pre_async");
    #2;
    reset = 1;
    #1;
    check("async.regWrite", 32'(regWrite), 0);
    check("async.data", write_data, 0);
    check("async.count", retired_count, 0);
    check("async.wb_valid", 32'(wb_valid), 0);
    drive(1, 1, 0, 5'd4, 32'h44, 0, 1, 1);
    @(posedge clk);
    #1;
    reset = 0;
    m_valid = 0; m_rw = 0; m_num = 0; m_data = 0; m_cnt = 0;
    check_model("post_reset");
    drive(1, 1, 0, 5'd4, 32'h44, 0, 0, 0);
    tick();
    check_model("first_capture");

    do_reset();
    for (int i = 1; i <= 17; i++) begin
      drive(1, 1, 0, 5'(i), 32'(i), 0, 0, 0);
      tick();
      if (i == 16) check("wrap.count4_15", 32'(retired_count4), 15);
      if (i == 17) check("wrap.count4_0", 32'(retired_count4), 0);
    end
    check_model("wrap_end");

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 5'($urandom),
            $urandom, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
